// File: rtl/clk_div_multi_pkg.sv
// Shared types and constants for the multi-channel programmable clock divider.
package clk_div_multi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  localparam int unsigned CntWidthDef = 16;
  typedef logic [CntWidthDef-1:0] cnt_t;

  // Smallest divisor that still yields one high and one low cycle.
  localparam int unsigned MinDiv = 2;

endpackage

// File: rtl/clk_div_multi_if.sv
// Divisor configuration port. A request is taken on the cycle where cfg_valid_i & cfg_ready_o.
interface clk_div_multi_if #(
  parameter int NumChannels = 2,
  parameter int CntWidth    = 16
);
  localparam int ChW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  logic                cfg_valid_i;
  logic                cfg_ready_o;
  logic [ChW-1:0]      cfg_ch_i;
  logic [CntWidth-1:0] cfg_div_i;

  modport master (output cfg_valid_i, cfg_ch_i, cfg_div_i, input cfg_ready_o);
  modport slave  (input cfg_valid_i, cfg_ch_i, cfg_div_i, output cfg_ready_o);
endinterface

// File: rtl/clk_div_multi_channel.sv
// One divider channel: IDLE/RUN FSM, period counter and a single-entry pending divisor.
module clk_div_channel
  import clk_div_multi_pkg::*;
#(
  parameter int CntWidth      = 16,
  parameter int DefaultDiv    = 610,
  parameter int EnableAtReset = 0
) (
  input  logic                soc_clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [CntWidth-1:0] load_div,
  output logic                div_clk,
  output logic                tick,
  output logic                running,
  output logic                pend
);

  ch_state_e           state_q;
  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] div_q;
  logic [CntWidth-1:0] pend_div_q;
  logic [CntWidth-1:0] hi;
  logic                pend_q;
  logic                clk_q;

  // High phase takes the extra cycle for odd divisors.
  assign hi = div_q - (div_q >> 1);

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= (EnableAtReset != 0) ? RUN : IDLE;
      cnt_q      <= '0;
      div_q      <= CntWidth'(DefaultDiv);
      pend_div_q <= CntWidth'(DefaultDiv);
      pend_q     <= 1'b0;
      clk_q      <= (EnableAtReset != 0);
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          clk_q <= 1'b0;
          if (pend_q) begin
            div_q  <= pend_div_q;
            pend_q <= 1'b0;
          end
          if (en) begin
            state_q <= RUN;
            clk_q   <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_q == div_q - 1'b1) begin
            if (pend_q) begin
              div_q  <= pend_div_q;
              pend_q <= 1'b0;
            end
            cnt_q <= '0;
            if (en) begin
              clk_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              clk_q   <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
            clk_q <= (cnt_q + 1'b1 < hi);
          end
        end
        default: state_q <= IDLE;
      endcase
      // Loads are only offered while nothing is pending, so this never races the apply above.
      if (load) begin
        pend_div_q <= load_div;
        pend_q     <= 1'b1;
      end
    end
  end

  assign div_clk = clk_q;
  assign tick    = (state_q == RUN) && (cnt_q == '0);
  assign running = (state_q == RUN);
  assign pend    = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider: config decode, ready mux and channel array.
module clk_div_multi
  import clk_div_multi_pkg::*;
#(
  parameter int NumChannels   = 2,
  parameter int CntWidth      = 16,
  parameter int DefaultDiv    = 610,
  parameter int EnableAtReset = 0
) (
  input  logic                   soc_clk,
  input  logic                   rst_n,
  input  logic [NumChannels-1:0] en_i,
  clk_div_multi_if.slave         cfg,
  output logic [NumChannels-1:0] clk_o,
  output logic [NumChannels-1:0] tick_o,
  output logic [NumChannels-1:0] running_o
);

  localparam int ChW = (NumChannels > 1) ? $clog2(NumChannels) : 1;

  logic [NumChannels-1:0] pend;
  logic [NumChannels-1:0] load;
  logic [CntWidth-1:0]    load_div;

  assign load_div = (cfg.cfg_div_i < CntWidth'(MinDiv)) ? CntWidth'(MinDiv) : cfg.cfg_div_i;

  // Out-of-range channel numbers match nothing: ready stays high and the request is dropped.
  always_comb begin
    cfg.cfg_ready_o = 1'b1;
    load            = '0;
    for (int i = 0; i < NumChannels; i++) begin
      if (cfg.cfg_ch_i == ChW'(i)) begin
        cfg.cfg_ready_o = ~pend[i];
        load[i]         = cfg.cfg_valid_i & ~pend[i];
      end
    end
  end

  for (genvar g = 0; g < NumChannels; g++) begin : g_ch
    clk_div_channel #(
      .CntWidth     (CntWidth),
      .DefaultDiv   (DefaultDiv),
      .EnableAtReset(EnableAtReset)
    ) u_ch (
      .soc_clk (soc_clk),
      .rst_n   (rst_n),
      .en      (en_i[g]),
      .load    (load[g]),
      .load_div(load_div),
      .div_clk (clk_o[g]),
      .tick    (tick_o[g]),
      .running (running_o[g]),
      .pend    (pend[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios plus random traffic against a per-period waveform model.
module tb_clk_div_multi;

  localparam int NC  = 3;
  localparam int W   = 16;
  localparam int DEF = 610;

  logic          soc_clk;
  logic          rst_n;
  logic [NC-1:0] en_i;
  logic [NC-1:0] clk_o;
  logic [NC-1:0] tick_o;
  logic [NC-1:0] running_o;

  int total = 0;
  int bad   = 0;

  clk_div_multi_if #(.NumChannels(NC), .CntWidth(W)) cfg_if ();

  clk_div_multi #(
    .NumChannels  (NC),
    .CntWidth     (W),
    .DefaultDiv   (DEF),
    .EnableAtReset(0)
  ) dut (
    .soc_clk  (soc_clk),
    .rst_n    (rst_n),
    .en_i     (en_i),
    .cfg      (cfg_if),
    .clk_o    (clk_o),
    .tick_o   (tick_o),
    .running_o(running_o)
  );

  // clock/reset block
  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Reference model: each running channel holds the remaining {tick,clk} samples of its current period.
  bit         m_run  [NC];
  int         m_div  [NC];
  int         m_pdiv [NC];
  bit         m_pend [NC];
  logic [1:0] exp_q  [NC][$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) begin
      m_run[i]  = 1'b0;
      m_div[i]  = DEF;
      m_pdiv[i] = DEF;
      m_pend[i] = 1'b0;
      exp_q[i].delete();
    end
  endfunction

  function automatic void start_period(int i);
    int n;
    n = m_div[i];
    exp_q[i].delete();
    for (int k = 0; k < n; k++) exp_q[i].push_back({(k == 0), (k < n - n / 2)});
  endfunction

  function automatic void model_step(logic [NC-1:0] en, logic v, int ch, int dv);
    bit was_pend;
    for (int i = 0; i < NC; i++) begin
      was_pend = m_pend[i];
      if (!m_run[i] || exp_q[i].size() == 1) begin
        if (was_pend) begin
          m_div[i]  = m_pdiv[i];
          m_pend[i] = 1'b0;
        end
        if (en[i]) begin
          m_run[i] = 1'b1;
          start_period(i);
        end else begin
          m_run[i] = 1'b0;
          exp_q[i].delete();
        end
      end else begin
        void'(exp_q[i].pop_front());
      end
      if (v && ch == i && !was_pend) begin
        m_pend[i] = 1'b1;
        m_pdiv[i] = (dv < 2) ? 2 : dv;
      end
    end
  endfunction

  // driver: one soc_clk cycle with the given inputs; outputs are compared mid-cycle
  task automatic cycle(input logic [NC-1:0] en, input logic v, input logic [1:0] ch,
                       input logic [W-1:0] dv);
    logic [NC-1:0] ec, et, er;
    logic [1:0]    h;
    logic          erdy;
    @(negedge soc_clk);
    en_i               = en;
    cfg_if.cfg_valid_i = v;
    cfg_if.cfg_ch_i    = ch;
    cfg_if.cfg_div_i   = dv;
    #1;
    for (int i = 0; i < NC; i++) begin
      er[i] = m_run[i];
      ec[i] = 1'b0;
      et[i] = 1'b0;
      if (m_run[i]) begin
        h     = exp_q[i][0];
        ec[i] = h[0];
        et[i] = h[1];
      end
    end
    erdy = (int'(ch) < NC) ? !m_pend[ch] : 1'b1;
    check("clk_o", clk_o, ec);
    check("tick_o", tick_o, et);
    check("running_o", running_o, er);
    check("cfg_ready", cfg_if.cfg_ready_o, erdy);
    model_step(en, v, int'(ch), int'(dv));
  endtask

  task automatic idle_cycles(input int n, input logic [NC-1:0] en);
    for (int k = 0; k < n; k++) cycle(en, 1'b0, 2'd0, '0);
  endtask

  task automatic do_reset();
    @(negedge soc_clk);
    rst_n              = 1'b0;
    cfg_if.cfg_valid_i = 1'b0;
    en_i               = '0;
    #1;
    check("rst_clk_o", clk_o, 0);
    check("rst_tick_o", tick_o, 0);
    check("rst_running_o", running_o, 0);
    check("rst_ready", cfg_if.cfg_ready_o, 1);
    model_reset();
    repeat (2) @(negedge soc_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int            hi_cnt;
    int            tick_cnt;
    logic [NC-1:0] en_r;
    rst_n              = 1'b1;
    en_i               = '0;
    cfg_if.cfg_valid_i = 1'b0;
    cfg_if.cfg_ch_i    = '0;
    cfg_if.cfg_div_i   = '0;
    model_reset();
    #2;
    do_reset();

    // default 610 on ch0: 305 high, one tick per period
    cycle(3'b001, 1'b0, 2'd0, '0);
    hi_cnt   = 0;
    tick_cnt = 0;
    for (int k = 0; k < DEF; k++) begin
      cycle(3'b001, 1'b0, 2'd0, '0);
      hi_cnt   += int'(clk_o[0]);
      tick_cnt += int'(tick_o[0]);
    end
    check("ch0_high_cycles", hi_cnt, DEF - DEF / 2);
    check("ch0_ticks", tick_cnt, 1);

    // ch1 programmed while idle, then enabled at 5 and later switched to 2
    cycle(3'b001, 1'b1, 2'd1, 16'd5);
    idle_cycles(2, 3'b001);
    idle_cycles(30, 3'b011);
    cycle(3'b011, 1'b1, 2'd1, 16'd2);
    idle_cycles(20, 3'b011);

    // ch0 reprogrammed mid-period; a second request waits for the boundary
    idle_cycles(100, 3'b011);
    cycle(3'b011, 1'b1, 2'd0, 16'd4);
    for (int k = 0; k < 650; k++) cycle(3'b011, 1'b1, 2'd0, 16'd6);
    idle_cycles(20, 3'b011);

    // back to 610, drop en mid-period, then re-enable
    cycle(3'b011, 1'b1, 2'd0, 16'd610);
    idle_cycles(10, 3'b011);
    idle_cycles(100, 3'b011);
    idle_cycles(700, 3'b010);
    idle_cycles(40, 3'b011);

    // clamping of 0/1 and an out-of-range channel
    cycle(3'b011, 1'b1, 2'd1, 16'd0);
    cycle(3'b011, 1'b1, 2'd2, 16'd1);
    cycle(3'b011, 1'b1, 2'd3, 16'd9);
    idle_cycles(30, 3'b111);

    // reset mid-period with a pending divisor; default comes back afterwards
    cycle(3'b111, 1'b1, 2'd0, 16'd7);
    idle_cycles(5, 3'b111);
    do_reset();
    idle_cycles(DEF + 10, 3'b001);

    // random traffic
    en_r = 3'b000;
    for (int k = 0; k < 3000; k++) begin
      logic [1:0]   rch;
      logic [W-1:0] rdv;
      for (int i = 0; i < NC; i++)
        if ($urandom_range(0, 39) == 0) en_r[i] = ~en_r[i];
      rch = 2'($urandom_range(0, 3));
      rdv = ($urandom_range(0, 9) == 0) ? W'($urandom_range(0, 40)) : W'($urandom_range(0, 9));
      cycle(en_r, ($urandom_range(0, 3) == 0), rch, rdv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
